// File: rtl/mole_sequencer.sv
// mole_sequencer: whack-a-mole game sequencer.
// Picks pseudo-random mole positions, times the POP window and the HIT/MISS
// display in tick pulses, and keeps the score and miss tallies for a game of
// ROUNDS rounds.
// Optional feature: define MOLE_SPEEDUP_EN to shorten the POP window by one
// tick per ten points scored (minimum window of 2 ticks).
//
// state  | meaning
// S_IDLE | after reset, waiting for a start edge
// S_PICK | drawing LFSR candidates until a new position in 1..10 comes up
// S_POP  | mole shown, waiting for its button or for the window to expire
// S_HIT  | hit display for HIT_TICKS ticks
// S_MISS | miss display for HIT_TICKS ticks
// S_OVER | all rounds played, done high, waiting for a start edge
module mole_sequencer #(
  parameter int POP_TICKS = 8,
  parameter int HIT_TICKS = 3,
  parameter int ROUNDS    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] btn,
  output logic [5:0] Q,
  output logic [1:0] state,
  output logic [6:0] score,
  output logic [6:0] miss_cnt,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_POP, S_HIT, S_MISS, S_OVER
  } fsm_t;

  fsm_t       fsm, fsm_next;
  logic [7:0] lfsr;
  logic       start_q;
  logic [9:0] btn_q;
  logic [3:0] last_pos, last_next;
  logic [4:0] round, round_next;
  logic [7:0] tick_cnt, cnt_next;
  logic [7:0] window_r, win_next, win_calc;
  logic [5:0] q_next;
  logic [1:0] state_next;
  logic [6:0] score_next, miss_next;
  logic       done_next;

  logic       start_edge;
  logic [9:0] btn_edge;
  logic [9:0] pos_mask;
  logic       hit_edge;
  logic [3:0] cand;
  logic       cand_ok;
  logic [4:0] round_inc;
  logic [6:0] score_inc;
  logic [6:0] miss_inc;

  assign start_edge = start & ~start_q;
  assign btn_edge   = btn & ~btn_q;
  // Q of 0 gives a shift of 15, so no button matches outside a round.
  assign pos_mask   = 10'd1 << (Q[3:0] - 4'd1);
  assign hit_edge   = |(btn_edge & pos_mask);
  assign cand       = lfsr[3:0];
  assign cand_ok    = (cand >= 4'd1) && (cand <= 4'd10) && (cand != last_pos);
  assign round_inc  = round + 5'd1;
  assign score_inc  = (score == 7'd99) ? score : score + 7'd1;
  assign miss_inc   = (miss_cnt == 7'd99) ? miss_cnt : miss_cnt + 7'd1;

`ifdef MOLE_SPEEDUP_EN
  // Window shrinks by score/10 ticks, floored at 2; sampled when the mole pops.
  assign win_calc = (8'(POP_TICKS) > ({1'b0, score / 7'd10} + 8'd1))
                    ? 8'(POP_TICKS) - {1'b0, score / 7'd10}
                    : 8'd2;
`else
  assign win_calc = 8'(POP_TICKS);
`endif

  // Next-state, next-output and counter logic.
  always_comb begin
    fsm_next   = fsm;
    q_next     = Q;
    score_next = score;
    miss_next  = miss_cnt;
    round_next = round;
    done_next  = done;
    last_next  = last_pos;
    win_next   = window_r;
    cnt_next   = tick ? tick_cnt + 8'd1 : tick_cnt;
    case (fsm)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          fsm_next   = S_PICK;
          score_next = 7'd0;
          miss_next  = 7'd0;
          round_next = 5'd0;
          done_next  = 1'b0;
          q_next     = 6'd0;
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          fsm_next  = S_POP;
          q_next    = {2'b00, cand};
          last_next = cand;
          win_next  = win_calc;
        end
      end
      S_POP: begin
        // A hit in the same cycle as the final tick still counts as a hit.
        if (hit_edge) begin
          fsm_next   = S_HIT;
          score_next = score_inc;
        end else if (tick && (tick_cnt == window_r - 8'd1)) begin
          fsm_next  = S_MISS;
          miss_next = miss_inc;
        end
      end
      S_HIT, S_MISS: begin
        if (tick && (tick_cnt == 8'(HIT_TICKS - 1))) begin
          round_next = round_inc;
          q_next     = 6'd0;
          if (round_inc == 5'(ROUNDS)) begin
            fsm_next  = S_OVER;
            done_next = 1'b1;
          end else begin
            fsm_next = S_PICK;
          end
        end
      end
      default: begin
        fsm_next = S_IDLE;
        q_next   = 6'd0;
      end
    endcase
    if (fsm_next != fsm) cnt_next = 8'd0;
    case (fsm_next)
      S_POP:   state_next = 2'b01;
      S_HIT:   state_next = 2'b10;
      S_MISS:  state_next = 2'b11;
      default: state_next = 2'b00;
    endcase
  end

  // State, LFSR, edge history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= S_IDLE;
      lfsr     <= 8'hA5;
      start_q  <= 1'b0;
      btn_q    <= 10'd0;
      last_pos <= 4'd0;
      round    <= 5'd0;
      tick_cnt <= 8'd0;
      window_r <= 8'(POP_TICKS);
      Q        <= 6'd0;
      state    <= 2'b00;
      score    <= 7'd0;
      miss_cnt <= 7'd0;
      done     <= 1'b0;
    end else begin
      fsm      <= fsm_next;
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start_q  <= start;
      btn_q    <= btn;
      last_pos <= last_next;
      round    <= round_next;
      tick_cnt <= cnt_next;
      window_r <= win_next;
      Q        <= q_next;
      state    <= state_next;
      score    <= score_next;
      miss_cnt <= miss_next;
      done     <= done_next;
    end
  end

endmodule
